// File: rtl/alu_writeback_pipe_if.sv
// Instruction issue and register-bank bundle between the upstream issuer,
// the register bank and the ALU writeback pipe.
interface alu_writeback_pipe_if;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  opcode;
   logic [4:0]  in_sr1;
   logic [4:0]  in_sr2;
   logic [4:0]  in_dr;
   logic [4:0]  sr1;
   logic [4:0]  sr2;
   logic [31:0] read_data_1;
   logic [31:0] read_data_2;
   logic [4:0]  dr;
   logic        write;
   logic [31:0] write_data;

   // Upstream issuer plus register bank, seen from outside the pipe.
   modport master (
      output in_valid, opcode, in_sr1, in_sr2, in_dr, read_data_1, read_data_2,
      input  in_ready, sr1, sr2, dr, write, write_data
   );

   // The pipe itself.
   modport slave (
      input  in_valid, opcode, in_sr1, in_sr2, in_dr, read_data_1, read_data_2,
      output in_ready, sr1, sr2, dr, write, write_data
   );
endinterface

// File: rtl/alu_writeback_pipe.sv
// Three-stage ALU pipe (accept/operand read, EX, WB) with EX/WB operand
// forwarding and a 4-cycle multiply that stalls issue while it runs.
module alu_writeback_pipe (
   input  logic                 clk,
   input  logic                 reset,
   alu_writeback_pipe_if.slave  bus
);

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_SLT = 3'd5,
      OP_MUL = 3'd6,
      OP_NOP = 3'd7
   } op_e;

   logic        ex_valid;
   op_e         ex_op;
   logic [4:0]  ex_dr;
   logic [31:0] ex_a;
   logic [31:0] ex_b;
   logic [1:0]  ex_cnt;

   logic        wb_valid;
   logic        wb_nop;
   logic [4:0]  wb_dr;
   logic [31:0] wb_data;

   logic        ex_stall;
   logic        ex_fwd_ok;
   logic        take;
   logic [31:0] ex_result;
   logic [31:0] opnd_a;
   logic [31:0] opnd_b;

   assign bus.sr1 = bus.in_sr1;
   assign bus.sr2 = bus.in_sr2;

   // A MUL with a nonzero count still owns EX; everything upstream waits.
   assign ex_stall     = ex_valid && (ex_op == OP_MUL) && (ex_cnt != 2'd0);
   assign bus.in_ready = !reset && !ex_stall;
   assign take         = bus.in_valid && bus.in_ready;
   assign ex_fwd_ok    = ex_valid && !ex_stall && (ex_op != OP_NOP);

   assign bus.write      = wb_valid && !wb_nop;
   assign bus.dr         = wb_dr;
   assign bus.write_data = wb_data;

   always_comb begin
      ex_result = 32'd0;
      unique case (ex_op)
         OP_ADD:  ex_result = ex_a + ex_b;
         OP_SUB:  ex_result = ex_a - ex_b;
         OP_AND:  ex_result = ex_a & ex_b;
         OP_OR:   ex_result = ex_a | ex_b;
         OP_XOR:  ex_result = ex_a ^ ex_b;
         OP_SLT:  ex_result = ($signed(ex_a) < $signed(ex_b)) ? 32'd1 : 32'd0;
         OP_MUL:  ex_result = ex_a * ex_b;
         OP_NOP:  ex_result = 32'd0;
         default: ex_result = 32'd0;
      endcase
   end

   // Youngest producer wins: EX result, then the value being written back, then the bank.
   always_comb begin
      opnd_a = bus.read_data_1;
      if (ex_fwd_ok && (ex_dr == bus.in_sr1)) begin
         opnd_a = ex_result;
      end else if (bus.write && (bus.dr == bus.in_sr1)) begin
         opnd_a = bus.write_data;
      end
   end

   always_comb begin
      opnd_b = bus.read_data_2;
      if (ex_fwd_ok && (ex_dr == bus.in_sr2)) begin
         opnd_b = ex_result;
      end else if (bus.write && (bus.dr == bus.in_sr2)) begin
         opnd_b = bus.write_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_valid <= 1'b0;
         ex_op    <= OP_NOP;
         ex_dr    <= 5'd0;
         ex_a     <= 32'd0;
         ex_b     <= 32'd0;
         ex_cnt   <= 2'd0;
         wb_valid <= 1'b0;
         wb_nop   <= 1'b1;
         wb_dr    <= 5'd0;
         wb_data  <= 32'd0;
      end else if (ex_stall) begin
         ex_cnt   <= ex_cnt - 2'd1;
         wb_valid <= 1'b0;
         wb_nop   <= 1'b1;
      end else begin
         wb_valid <= ex_valid;
         wb_nop   <= (ex_op == OP_NOP);
         if (ex_valid && (ex_op != OP_NOP)) begin
            wb_dr   <= ex_dr;
            wb_data <= ex_result;
         end
         ex_valid <= take;
         if (take) begin
            ex_op  <= op_e'(bus.opcode);
            ex_dr  <= bus.in_dr;
            ex_a   <= opnd_a;
            ex_b   <= opnd_b;
            ex_cnt <= (op_e'(bus.opcode) == OP_MUL) ? 2'd3 : 2'd0;
         end else begin
            ex_cnt <= 2'd0;
         end
      end
   end

endmodule

// File: tb/tb_alu_writeback_pipe.sv
// Directed bench for alu_writeback_pipe: a behavioural register bank sits on
// the bus, and hand-computed results are checked with immediate assertions.
module tb_alu_writeback_pipe;

   logic clk;
   logic reset;
   int   errors;
   int   checks;
   logic [31:0] bank [32];

   alu_writeback_pipe_if bus ();

   alu_writeback_pipe dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bus.read_data_1 = bank[bus.sr1];
   assign bus.read_data_2 = bank[bus.sr2];

   always @(posedge clk) begin
      if (bus.write) bank[bus.dr] <= bus.write_data;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] op, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [4:0] d);
      bus.in_valid = 1'b1;
      bus.opcode   = op;
      bus.in_sr1   = s1;
      bus.in_sr2   = s2;
      bus.in_dr    = d;
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
      bus.opcode   = 3'd7;
   endtask

   task automatic chk_wb(input string tag, input logic [4:0] d, input logic [31:0] data);
      chk({tag, "_write"}, 32'(bus.write), 32'd1);
      chk({tag, "_dr"}, 32'(bus.dr), 32'(d));
      chk({tag, "_data"}, bus.write_data, data);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      for (int i = 0; i < 32; i++) bank[i] = 32'd0;
      bank[1]  = 32'd10;
      bank[2]  = 32'd3;
      bank[9]  = 32'd1;
      bank[10] = 32'hFFFF_FFFF;
      bank[11] = 32'h0001_0000;

      reset = 1'b1;
      idle();
      bus.in_sr1 = 5'd9;
      bus.in_sr2 = 5'd17;
      bus.in_dr  = 5'd0;
      tick();
      tick();
      chk("rst_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_write", 32'(bus.write), 32'd0);
      chk("rst_dr", 32'(bus.dr), 32'd0);
      chk("rst_data", bus.write_data, 32'd0);
      chk("sr1_comb", 32'(bus.sr1), 32'd9);
      chk("sr2_comb", 32'(bus.sr2), 32'd17);

      // First transfer in the first cycle out of reset: ADD r3,r1,r2.
      reset = 1'b0;
      issue(3'd0, 5'd1, 5'd2, 5'd3);
      #1;
      chk("first_ready", 32'(bus.in_ready), 32'd1);
      tick();
      chk("add_ex_nowrite", 32'(bus.write), 32'd0);
      issue(3'd1, 5'd3, 5'd1, 5'd4);          // SUB r4,r3,r1 (r3 from EX)
      tick();
      chk_wb("add", 5'd3, 32'd13);
      issue(3'd2, 5'd3, 5'd4, 5'd5);          // AND r5,r3,r4 (r3 from WB, r4 from EX)
      tick();
      chk_wb("sub", 5'd4, 32'd3);
      idle();
      tick();
      chk_wb("and", 5'd5, 32'd1);
      tick();
      chk("drain_write", 32'(bus.write), 32'd0);
      chk("bank_r3", bank[3], 32'd13);

      // MUL r6,r1,r2 then ADD r7,r6,r1 held valid through the stall.
      issue(3'd6, 5'd1, 5'd2, 5'd6);
      tick();
      issue(3'd0, 5'd6, 5'd1, 5'd7);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("mul_stall_ready%0d", i), 32'(bus.in_ready), 32'd0);
         chk($sformatf("mul_bubble%0d", i), 32'(bus.write), 32'd0);
         tick();
      end
      chk("mul_done_ready", 32'(bus.in_ready), 32'd1);
      tick();
      chk_wb("mul", 5'd6, 32'd30);
      idle();
      tick();
      chk_wb("add_fwd_mul", 5'd7, 32'd40);
      tick();
      chk("held_add_once", 32'(bus.write), 32'd0);

      // Arithmetic edge cases.
      issue(3'd1, 5'd8, 5'd9, 5'd12);         // SUB 0-1
      tick();
      issue(3'd5, 5'd10, 5'd9, 5'd13);        // SLT -1 < 1
      tick();
      chk_wb("sub_wrap", 5'd12, 32'hFFFF_FFFF);
      issue(3'd6, 5'd11, 5'd11, 5'd14);       // MUL 0x10000*0x10000
      tick();
      chk_wb("slt_signed", 5'd13, 32'd1);
      issue(3'd7, 5'd0, 5'd0, 5'd15);         // NOP held behind the MUL
      tick();
      tick();
      tick();
      chk("mul2_bubble", 32'(bus.write), 32'd0);
      chk("mul2_ready", 32'(bus.in_ready), 32'd1);
      tick();
      chk_wb("mul_wrap", 5'd14, 32'd0);
      issue(3'd0, 5'd1, 5'd2, 5'd0);          // ADD r0,r1,r2
      tick();
      chk("nop_nowrite", 32'(bus.write), 32'd0);
      idle();
      tick();
      chk_wb("write_r0", 5'd0, 32'd13);
      tick();

      // Reset pulse during the MUL's second EX cycle.
      issue(3'd6, 5'd1, 5'd2, 5'd16);
      tick();
      idle();
      tick();
      reset = 1'b1;
      tick();
      chk("midmul_rst_write", 32'(bus.write), 32'd0);
      chk("midmul_rst_ready", 32'(bus.in_ready), 32'd0);
      reset = 1'b0;
      #1;
      chk("post_rst_ready", 32'(bus.in_ready), 32'd1);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("post_rst_nowrite%0d", i), 32'(bus.write), 32'd0);
         tick();
      end
      chk("bank_r16_untouched", bank[16], 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_writeback_pipe.md
ALU_WRITEBACK_PIPE -- requirements
Module: alu_writeback_pipe

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 and register addresses at 5 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  instruction offered this cycle.
REQ-005 in_ready  output  1  block accepts the instruction this cycle; an instruction transfers when in_valid && in_ready.
REQ-006 opcode  input  3  operation code: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 MUL, 7 NOP.
REQ-007 in_sr1, in_sr2, in_dr  input  5 each  source and destination register numbers.
REQ-008 sr1, sr2  output  5 each  register-bank read addresses.
REQ-009 read_data_1, read_data_2  input  32 each  register-bank read data; combinational from sr1/sr2.
REQ-010 dr  output  5  register-bank write address.
REQ-011 write  output  1  register-bank write enable.
REQ-012 write_data  output  32  register-bank write data.

Function
REQ-013 sr1 SHALL equal in_sr1 and sr2 SHALL equal in_sr2 combinationally in every cycle.
REQ-014 Pipeline SHALL have three stages: ACCEPT (operand read), EX (register stage), WB (register stage driving write/dr/write_data).
REQ-015 On transfer at edge N, EX SHALL capture opcode, dr and both forwarded operands.
REQ-016 A single-cycle op SHALL be in WB after edge N+1, with write=1 for exactly one cycle, so the bank commits it at edge N+2.
REQ-017 NOP SHALL advance through EX and WB with write=0.
REQ-018 ADD/SUB/MUL SHALL produce the low 32 bits of the result, with wrap-around and no flags.
REQ-019 SLT SHALL produce 32'd1 if operand A < operand B (two's complement), else 0.
REQ-020 Operand forwarding priority, evaluated per operand: (a) EX holds a completed non-NOP op whose dr matches → EX result; (b) else write=1 and dr matches → write_data; (c) else read_data_1/2.
REQ-021 MUL SHALL occupy EX for 4 cycles; an EX counter SHALL load 3 on entry and decrement each cycle, and the result is complete when the count reaches 0.
REQ-022 in_ready SHALL be 0 while EX holds a MUL with count ≠ 0, and 1 otherwise (outside reset).
REQ-023 While EX is stalled, WB SHALL receive a bubble (write=0) each cycle until the MUL leaves.
REQ-024 An op accepted in the MUL's final EX cycle SHALL see the MUL result via forwarding rule (a).
REQ-025 in_valid while in_ready=0 SHALL be ignored; no state changes, and the upstream holds its inputs.
REQ-026 Back-to-back transfers SHALL sustain one instruction per cycle for non-MUL ops.
REQ-027 Writes to any of registers 0–31 SHALL be permitted, including register 0.

Reset
REQ-028 While reset=1 at an edge, EX and WB valid bits SHALL clear, the MUL counter SHALL be 0, and write=0, dr=0, write_data=0.
REQ-029 in_ready SHALL be 0 during any cycle with reset=1.
REQ-030 Reset asserted mid-MUL or mid-pipeline SHALL discard all in-flight ops, with no write afterwards.
REQ-031 After reset, the first transfer SHALL be possible in the first cycle with reset=0.

Verification
REQ-032 Bank preloaded r1=10, r2=3; issue ADD r3,r1,r2 → write=1, dr=3, write_data=13 two cycles after acceptance.
REQ-033 Back-to-back ADD r3,r1,r2 then SUB r4,r3,r1, then AND r5,r3,r4 → write_data 13, 3, 1 on consecutive cycles (EX and WB forwarding).
REQ-034 MUL r6,r1,r2 followed by ADD r7,r6,r1 held valid → in_ready low for 3 cycles; r6=30, then r7=40.
REQ-035 Arithmetic edge cases: SUB 0−1 → 32'hFFFFFFFF; SLT −1 < 1 → 1; MUL 32'h10000 × 32'h10000 → 0; NOP → no write.
REQ-036 Assert reset for one cycle during a MUL's second EX cycle → no write ever issued for that MUL; in_ready=1 on the next cycle.
